eth_rx_demux: RTL and testbench
===============================

// Module: eth_rx_demux
// PURPOSE
//  Byte-wide Ethernet RX front end between MAC RX AXIS and protocol engines (IP, ARP, ...).
//  Filters destination MAC (local/broadcast/promiscuous) and matches EtherType against a
//  NUM_CH-entry table. Strips the 14-byte header and forwards the payload, with full AXIS
//  backpressure, to the matching channel. Drops unknown frames; terminates stalled frames with an error beat.
// PARAMETERS
//  NUM_CH     2             number of output channels (1..8)
//  ETYPE_LIST 32'h0806_0800 EtherType table, channel i = ETYPE_LIST[16*i +: 16] (ch0 IP, ch1 ARP)
//  TIMEOUT_W  12            idle timeout = 2**TIMEOUT_W cycles without s_axis_tvalid inside a frame
//  CNT_W      16            width of statistics counters
// PORTS
//  clk            in  1         clock
//  reset          in  1         synchronous, active-high
//  local_mac      in  48        station MAC, byte 0 of frame = local_mac[47:40]
//  promisc        in  1         1: accept any destination MAC
//  s_axis_tdata   in  8         frame byte, from MAC RX
//  s_axis_tvalid  in  1
//  s_axis_tlast   in  1         last byte of frame (FCS already removed)
//  s_axis_tready  out 1
//  m_axis_tdata   out 8         shared payload bus
//  m_axis_tvalid  out NUM_CH    one-hot, channel select
//  m_axis_tlast   out 1
//  m_axis_tuser   out 1         1 on abort terminator beat only
//  m_axis_tready  in  NUM_CH
//  frame_cnt      out CNT_W     frames forwarded complete, wraps
//  drop_cnt       out CNT_W     frames dropped (MAC/EtherType miss, runt, empty payload), wraps
//  abort_cnt      out CNT_W     timeouts, wraps
// BEHAVIOUR
//  - Reset: state HDR, hdr_cnt=0, sel=0, all counters 0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0.
//    Reset mid-frame discards the frame silently. Remaining bytes are then parsed as a new header.
//  - States: HDR, FWD, DROP, ABORT. Transfer = tvalid & tready.
//  - HDR: s_axis_tready=1. 4-bit hdr_cnt counts bytes 0..13.
//    Bytes 0..5 are compared with local_mac; mac_ok is cleared on any mismatch, unless the frame is all-FF or promisc=1.
//    Bytes 12..13 are captured as EtherType.
//    At byte 13: if mac_ok and EtherType hits, sel = lowest matching index.
//    At byte 13 without tlast: FWD on a hit; DROP on a miss, drop_cnt++ when DROP completes.
//    tlast on any byte 0..13: stay HDR, hdr_cnt=0, drop_cnt++ (runt or empty payload).
//  - FWD: zero latency, combinational pass-through.
//    m_axis_tdata=s_axis_tdata, m_axis_tvalid[sel]=s_axis_tvalid, m_axis_tlast=s_axis_tlast, s_axis_tready=m_axis_tready[sel].
//    Other channels' tvalid = 0. Transfer with tlast -> HDR, frame_cnt++.
//  - DROP: s_axis_tready=1, no output. Transfer with tlast -> HDR.
//  - Idle timer: counts cycles with s_axis_tvalid=0 while in FWD, DROP, or HDR with hdr_cnt!=0. Clears on s_axis_tvalid=1.
//    Does not count while s_axis_tvalid=1 and the sink stalls. Reaching 2**TIMEOUT_W-1 asserts timeout for one cycle.
//  - Timeout in HDR/DROP -> HDR, hdr_cnt=0, abort_cnt++.
//  - Timeout in FWD -> ABORT, abort_cnt++.
//  - ABORT: s_axis_tready=0. Drives m_axis_tvalid[sel]=1, m_axis_tdata=0, m_axis_tlast=1, m_axis_tuser=1.
//    Holds until m_axis_tready[sel], then -> HDR. frame_cnt unchanged.
//  - Simultaneous events: a transfer and a timeout cannot coincide, because the timer clears on tvalid.
//    tlast on header byte 13 counts as a drop, never a forward.
//  - m_axis_tvalid stays stable while stalled, since it is derived from upstream, which obeys AXIS.
//    Stall length is unbounded in FWD while the sink is stalled.
// STRUCTURE
//  - Package eth_pkg: ETH_HDR_LEN=14, ETYPE_IP=16'h0800, ETYPE_ARP=16'h0806,
//    ETYPE_RARP=16'h8035, BCAST_MAC=48'hFFFF_FFFF_FFFF, state encoding.
//  - Sub-module rx_idle_timer (param W; in clk, reset, clr, en; out expired).
//  - EtherType match is a generate loop over NUM_CH comparators feeding a priority encoder.
// TESTING
//  1. Unicast to local_mac 02:00:00:00:00:01, type 0x0800, 46-byte payload, ready=1
//     -> ch0 gets exactly 46 beats, tlast on beat 46; frame_cnt=1.
//  2. Broadcast, type 0x0806, 28 bytes; m_axis_tready[1] toggling 1010..
//     -> ch1 gets 28 in-order beats; s_axis_tready mirrors m_axis_tready[1]; ch0 tvalid never 1.
//  3. Dest 02:00:00:00:00:02 (promisc=0), then type 0x86DD to local
//     -> no output, drop_cnt=2. Repeat with promisc=1 for the MAC case -> forwarded.
//  4. 10-byte runt with tlast, then 14-byte header-only frame -> drop_cnt=2; the next valid frame forwards correctly.
//  5. IP frame stalls after 5 payload bytes, tvalid=0 for 4096 cycles
//     -> ch0 gets beat tdata=0, tlast=1, tuser=1; abort_cnt=1; the next frame parses from byte 0.
//  6. Reset asserted mid-FWD on byte 20
//     -> all outputs and counters 0 next cycle; a following clean frame forwards with frame_cnt=1.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared constants and state encoding for the Ethernet RX demultiplexer.
package eth_pkg;

  localparam int          ETH_HDR_LEN = 14;
  localparam logic [15:0] ETYPE_IP    = 16'h0800;
  localparam logic [15:0] ETYPE_ARP   = 16'h0806;
  localparam logic [15:0] ETYPE_RARP  = 16'h8035;
  localparam logic [47:0] BCAST_MAC   = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    ST_HDR   = 2'd0,
    ST_FWD   = 2'd1,
    ST_DROP  = 2'd2,
    ST_ABORT = 2'd3
  } rx_state_e;

endpackage

// File: rtl/rx_idle_timer.sv
// Idle-cycle counter. It fires a single-cycle expired pulse on the cycle where
// the count has reached all-ones while still enabled, i.e. after 2**W idle cycles.
module rx_idle_timer #(
  parameter int W = 12
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [W-1:0] cnt_reg;

  // Count enabled idle cycles; the wrap to zero after expiry re-arms the timer.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign expired = en && (cnt_reg == {W{1'b1}});

endmodule

// File: rtl/eth_rx_demux.sv
// Byte-wide Ethernet RX front end: filters destination MAC, matches EtherType
// against a channel table, strips the 14-byte header and forwards the payload
// to one channel with zero latency. Stalled frames end with an abort beat.
module eth_rx_demux
  import eth_pkg::*;
#(
  parameter int                    NUM_CH     = 2,
  parameter logic [16*NUM_CH-1:0]  ETYPE_LIST = {ETYPE_ARP, ETYPE_IP},
  parameter int                    TIMEOUT_W  = 12,
  parameter int                    CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [47:0]       local_mac,
  input  logic              promisc,
  input  logic [7:0]        s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic [7:0]        m_axis_tdata,
  output logic [NUM_CH-1:0] m_axis_tvalid,
  output logic              m_axis_tlast,
  output logic              m_axis_tuser,
  input  logic [NUM_CH-1:0] m_axis_tready,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [CNT_W-1:0]  abort_cnt
);

  localparam int         SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [3:0] HDR_LAST = 4'(ETH_HDR_LEN - 1);

  rx_state_e         state_reg;
  logic [3:0]        hdr_cnt_reg;
  logic              ucast_ok_reg, bcast_ok_reg;
  logic [7:0]        etype_hi_reg;
  logic [SEL_W-1:0]  sel_reg;
  logic [CNT_W-1:0]  frame_cnt_reg, drop_cnt_reg, abort_cnt_reg;

  logic              s_xfer;
  logic [7:0]        mac_byte;
  logic              ucast_ok_next, bcast_ok_next, mac_ok;
  logic [15:0]       etype_now;
  logic [NUM_CH-1:0] etype_hit, sel_onehot;
  logic              any_hit;
  logic [SEL_W-1:0]  hit_idx;
  logic              timer_active, timer_en, timer_clr, timeout;

  assign s_xfer = s_axis_tvalid && s_axis_tready;

  // Pick the local MAC byte that lines up with the current header position.
  always_comb begin
    mac_byte = '0;
    for (int i = 0; i < 6; i++) begin
      if (hdr_cnt_reg == 4'(i)) mac_byte = local_mac[8*(5-i) +: 8];
    end
  end

  // Unicast and broadcast matches are tracked separately so an all-FF frame survives.
  assign ucast_ok_next = ((hdr_cnt_reg == 4'd0) ? 1'b1 : ucast_ok_reg) && (s_axis_tdata == mac_byte);
  assign bcast_ok_next = ((hdr_cnt_reg == 4'd0) ? 1'b1 : bcast_ok_reg) && (s_axis_tdata == BCAST_MAC[7:0]);
  assign mac_ok        = ucast_ok_reg || bcast_ok_reg || promisc;

  // The low EtherType byte is still on the bus at header byte 13.
  assign etype_now = {etype_hi_reg, s_axis_tdata};

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign etype_hit[gi]  = (etype_now == ETYPE_LIST[16*gi +: 16]);
    assign sel_onehot[gi] = (sel_reg == SEL_W'(gi));
  end

  // Priority encoder: the lowest-numbered matching channel wins.
  always_comb begin
    hit_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (etype_hit[i]) hit_idx = SEL_W'(i);
    end
  end
  assign any_hit = |etype_hit;

  // Idle timing only matters once a frame has started.
  assign timer_active = (state_reg == ST_FWD) || (state_reg == ST_DROP) ||
                        ((state_reg == ST_HDR) && (hdr_cnt_reg != 4'd0));
  assign timer_en  = timer_active && !s_axis_tvalid;
  assign timer_clr = !timer_active || s_axis_tvalid;

  rx_idle_timer #(.W(TIMEOUT_W)) u_idle_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (timeout)
  );

  // Frame-level state machine: header parse, forward, drop, abort, plus statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_HDR;
      hdr_cnt_reg   <= '0;
      ucast_ok_reg  <= 1'b0;
      bcast_ok_reg  <= 1'b0;
      etype_hi_reg  <= '0;
      sel_reg       <= '0;
      frame_cnt_reg <= '0;
      drop_cnt_reg  <= '0;
      abort_cnt_reg <= '0;
    end else begin
      case (state_reg)
        ST_HDR: begin
          if (timeout) begin
            hdr_cnt_reg   <= '0;
            abort_cnt_reg <= abort_cnt_reg + 1'b1;
          end else if (s_xfer) begin
            if (hdr_cnt_reg < 4'd6) begin
              ucast_ok_reg <= ucast_ok_next;
              bcast_ok_reg <= bcast_ok_next;
            end
            if (hdr_cnt_reg == 4'd12) etype_hi_reg <= s_axis_tdata;
            if ((hdr_cnt_reg == HDR_LAST) && mac_ok && any_hit) sel_reg <= hit_idx;
            if (s_axis_tlast) begin
              hdr_cnt_reg  <= '0;
              drop_cnt_reg <= drop_cnt_reg + 1'b1;
            end else if (hdr_cnt_reg == HDR_LAST) begin
              hdr_cnt_reg <= '0;
              state_reg   <= (mac_ok && any_hit) ? ST_FWD : ST_DROP;
            end else begin
              hdr_cnt_reg <= hdr_cnt_reg + 1'b1;
            end
          end
        end
        ST_FWD: begin
          if (timeout) begin
            state_reg     <= ST_ABORT;
            abort_cnt_reg <= abort_cnt_reg + 1'b1;
          end else if (s_xfer && s_axis_tlast) begin
            state_reg     <= ST_HDR;
            frame_cnt_reg <= frame_cnt_reg + 1'b1;
          end
        end
        ST_DROP: begin
          if (timeout) begin
            state_reg     <= ST_HDR;
            abort_cnt_reg <= abort_cnt_reg + 1'b1;
          end else if (s_xfer && s_axis_tlast) begin
            state_reg    <= ST_HDR;
            drop_cnt_reg <= drop_cnt_reg + 1'b1;
          end
        end
        ST_ABORT: begin
          if (|(m_axis_tready & sel_onehot)) state_reg <= ST_HDR;
        end
        default: state_reg <= ST_HDR;
      endcase
    end
  end

  // Output steering: pass-through in FWD, fixed terminator beat in ABORT.
  always_comb begin
    s_axis_tready = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tvalid = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    case (state_reg)
      ST_HDR, ST_DROP: s_axis_tready = 1'b1;
      ST_FWD: begin
        m_axis_tdata  = s_axis_tdata;
        m_axis_tvalid = sel_onehot & {NUM_CH{s_axis_tvalid}};
        m_axis_tlast  = s_axis_tlast;
        s_axis_tready = |(m_axis_tready & sel_onehot);
      end
      ST_ABORT: begin
        m_axis_tvalid = sel_onehot;
        m_axis_tlast  = 1'b1;
        m_axis_tuser  = 1'b1;
      end
      default: s_axis_tready = 1'b0;
    endcase
  end

  assign frame_cnt = frame_cnt_reg;
  assign drop_cnt  = drop_cnt_reg;
  assign abort_cnt = abort_cnt_reg;

endmodule

// File: tb/tb_eth_rx_demux.sv
// Bench for eth_rx_demux: directed scenarios followed by random frames, all
// checked against a frame-level reference model and an output beat scoreboard.
module tb_eth_rx_demux;
  import eth_pkg::*;

  localparam int          NUM_CH    = 2;
  localparam int          TIMEOUT_W = 12;
  localparam int          CNT_W     = 16;
  localparam logic [47:0] LOCAL     = 48'h02_00_00_00_00_01;
  localparam logic [47:0] OTHER     = 48'h02_00_00_00_00_02;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              promisc = 1'b0;
  logic [7:0]        s_axis_tdata = '0;
  logic              s_axis_tvalid = 1'b0;
  logic              s_axis_tlast = 1'b0;
  logic              s_axis_tready;
  logic [7:0]        m_axis_tdata;
  logic [NUM_CH-1:0] m_axis_tvalid;
  logic              m_axis_tlast;
  logic              m_axis_tuser;
  logic [NUM_CH-1:0] m_axis_tready = '1;
  logic [CNT_W-1:0]  frame_cnt, drop_cnt, abort_cnt;

  eth_rx_demux #(
    .NUM_CH    (NUM_CH),
    .ETYPE_LIST(32'h0806_0800),
    .TIMEOUT_W (TIMEOUT_W),
    .CNT_W     (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .local_mac    (LOCAL),
    .promisc      (promisc),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tuser (m_axis_tuser),
    .m_axis_tready(m_axis_tready),
    .frame_cnt    (frame_cnt),
    .drop_cnt     (drop_cnt),
    .abort_cnt    (abort_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         ch;
    logic [7:0] data;
    logic       last;
    logic       user;
  } beat_t;

  beat_t      got_q[$];
  beat_t      exp_q[$];
  logic [7:0] frame_q[$];
  int         exp_frame, exp_drop, exp_abort;
  int         valid_seen[NUM_CH];
  int         sink_mode;   // 0 all ready, 1 ch1 toggles each cycle, 2 random
  bit         chk_mirror;
  int         n_checks, n_errors;
  int         wait_n;
  logic [15:0] etype_table[NUM_CH] = '{16'h0800, 16'h0806};

  // Sink ready pattern generator.
  always @(posedge clk) begin
    #1;
    case (sink_mode)
      0:       m_axis_tready = '1;
      1:       m_axis_tready = {~m_axis_tready[1], 1'b1};
      default: m_axis_tready = 2'($urandom_range(0, 3));
    endcase
  end

  // Output monitor: records every accepted beat per channel.
  always @(negedge clk) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (m_axis_tvalid[c]) valid_seen[c]++;
        if (m_axis_tvalid[c] && m_axis_tready[c]) begin
          beat_t b;
          b.ch = c; b.data = m_axis_tdata; b.last = m_axis_tlast; b.user = m_axis_tuser;
          got_q.push_back(b);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    s_axis_tdata = d; s_axis_tlast = l; s_axis_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (chk_mirror) chk("mirror", s_axis_tready, m_axis_tready[1]);
      if (s_axis_tready) break;
      n++;
      if (n > 1000) begin
        chk("put_timeout", s_axis_tready, 1);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_bus();
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
  endtask

  task automatic build(input logic [47:0] dst, input logic [15:0] et, input int len);
    frame_q.delete();
    for (int i = 5; i >= 0; i--) frame_q.push_back(dst[8*i +: 8]);
    for (int i = 0; i < 6; i++) frame_q.push_back(8'($urandom));
    frame_q.push_back(et[15:8]);
    frame_q.push_back(et[7:0]);
    for (int i = 14; i < len; i++) frame_q.push_back(8'($urandom));
    while (frame_q.size() > len) void'(frame_q.pop_back());
  endtask

  // Reference model: decide the fate of a whole frame from its bytes.
  task automatic model();
    int          len, ch;
    logic [47:0] dst;
    logic [15:0] et;
    bit          mac_ok;
    len = frame_q.size();
    if (len <= 14) begin
      exp_drop++;
      return;
    end
    dst = {frame_q[0], frame_q[1], frame_q[2], frame_q[3], frame_q[4], frame_q[5]};
    et  = {frame_q[12], frame_q[13]};
    mac_ok = (dst == LOCAL) || (dst == 48'hFFFF_FFFF_FFFF) || promisc;
    ch = -1;
    for (int i = 0; i < NUM_CH; i++) if (ch < 0 && et == etype_table[i]) ch = i;
    if (mac_ok && ch >= 0) begin
      for (int i = 14; i < len; i++) begin
        beat_t b;
        b.ch = ch; b.data = frame_q[i]; b.last = (i == len - 1); b.user = 1'b0;
        exp_q.push_back(b);
      end
      exp_frame++;
    end else begin
      exp_drop++;
    end
  endtask

  task automatic send_all();
    for (int i = 0; i < frame_q.size(); i++) put(frame_q[i], i == frame_q.size() - 1);
    idle_bus();
  endtask

  task automatic check_frame(input string tag);
    int n;
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_nbeats"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk({tag, "_beat"}, {got_q[i].ch[3:0], got_q[i].data, got_q[i].last, got_q[i].user},
          {exp_q[i].ch[3:0], exp_q[i].data, exp_q[i].last, exp_q[i].user});
    chk({tag, "_frame_cnt"}, frame_cnt, 16'(exp_frame));
    chk({tag, "_drop_cnt"},  drop_cnt,  16'(exp_drop));
    chk({tag, "_abort_cnt"}, abort_cnt, 16'(exp_abort));
    $display("frame %s: len=%0d beats=%0d frame_cnt=%0d drop_cnt=%0d abort_cnt=%0d",
             tag, frame_q.size(), got_q.size(), frame_cnt, drop_cnt, abort_cnt);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic run(input string tag, input logic [47:0] dst, input logic [15:0] et, input int len);
    build(dst, et, len);
    model();
    send_all();
    check_frame(tag);
  endtask

  initial begin
    logic [47:0] dst;
    logic [15:0] et;
    sink_mode = 0;
    // Reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_abort_cnt", abort_cnt, 0);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_tuser", m_axis_tuser, 0);
    chk("rst_s_tready", s_axis_tready, 1);
    @(posedge clk); #1;

    // Unicast IP, 46-byte payload
    run("t1_ip46", LOCAL, 16'h0800, 60);

    // Broadcast ARP with toggling sink ready on ch1
    valid_seen[0] = 0;
    sink_mode = 1;
    build(48'hFFFF_FFFF_FFFF, 16'h0806, 42);
    model();
    for (int i = 0; i < 14; i++) put(frame_q[i], 1'b0);
    chk_mirror = 1'b1;
    for (int i = 14; i < 42; i++) put(frame_q[i], i == 41);
    chk_mirror = 1'b0;
    idle_bus();
    sink_mode = 0;
    check_frame("t2_arp_bcast");
    chk("t2_ch0_never_valid", valid_seen[0], 0);

    // MAC miss, EtherType miss, then promiscuous accept
    run("t3_mac_miss", OTHER, 16'h0800, 40);
    run("t3_etype_miss", LOCAL, 16'h86DD, 40);
    promisc = 1'b1;
    run("t3_promisc", OTHER, 16'h0800, 40);
    promisc = 1'b0;

    // Runt and header-only frames, then a good one
    run("t4_runt10", LOCAL, 16'h0800, 10);
    run("t4_hdr_only", LOCAL, 16'h0800, 14);
    run("t4_after", LOCAL, 16'h0806, 20);

    // Stall after 5 payload bytes -> abort terminator
    build(LOCAL, 16'h0800, 40);
    for (int i = 0; i < 19; i++) begin
      beat_t b;
      put(frame_q[i], 1'b0);
      if (i >= 14) begin
        b.ch = 0; b.data = frame_q[i]; b.last = 1'b0; b.user = 1'b0;
        exp_q.push_back(b);
      end
    end
    idle_bus();
    repeat (4000) @(posedge clk);
    #1;
    chk("t5_no_early_abort", abort_cnt, 16'(exp_abort));
    chk("t5_no_early_beat", got_q.size(), 5);
    begin
      beat_t b;
      b.ch = 0; b.data = 8'h00; b.last = 1'b1; b.user = 1'b1;
      exp_q.push_back(b);
    end
    exp_abort++;
    wait_n = 0;
    while (got_q.size() < 6 && wait_n < 300) begin
      @(posedge clk);
      wait_n++;
    end
    chk("t5_abort_seen", got_q.size() >= 6, 1);
    check_frame("t5_abort");
    run("t5_next", LOCAL, 16'h0800, 30);

    // Reset in the middle of forwarding, on byte 20
    build(LOCAL, 16'h0800, 60);
    for (int i = 0; i < 20; i++) put(frame_q[i], 1'b0);
    s_axis_tdata = frame_q[20]; s_axis_tvalid = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    idle_bus();
    @(negedge clk);
    chk("t6_frame_cnt", frame_cnt, 0);
    chk("t6_drop_cnt", drop_cnt, 0);
    chk("t6_abort_cnt", abort_cnt, 0);
    chk("t6_tvalid", m_axis_tvalid, 0);
    chk("t6_tlast", m_axis_tlast, 0);
    chk("t6_tuser", m_axis_tuser, 0);
    got_q.delete();
    exp_q.delete();
    exp_frame = 0; exp_drop = 0; exp_abort = 0;
    @(posedge clk); #1;
    run("t6_clean", LOCAL, 16'h0800, 50);

    // Random frames with random backpressure
    sink_mode = 2;
    for (int k = 0; k < 40; k++) begin
      promisc = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       dst = LOCAL;
        1:       dst = 48'hFFFF_FFFF_FFFF;
        2:       dst = OTHER;
        default: dst = {16'($urandom), 32'($urandom)};
      endcase
      case ($urandom_range(0, 3))
        0:       et = 16'h0800;
        1:       et = 16'h0806;
        2:       et = 16'h86DD;
        default: et = 16'($urandom);
      endcase
      run($sformatf("rnd%0d", k), dst, et, $urandom_range(1, 50));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    sink_mode = 0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
